// File: rtl/car_pkg.sv
// Shared definitions for the gear-shift controller: gear range,
// shift sequencer states and the per-gear downshift speed limits.
package car_pkg;

  localparam int GEAR_N           = 0;
  localparam int MAX_GEAR_DEFAULT = 6;
  localparam int GEAR_W           = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLUTCH = 2'd1,
    ST_SETTLE = 2'd2
  } shift_state_e;

  // Highest road speed (km/h) at which gear g may be newly engaged from
  // above or from neutral; gears outside the table carry no limit.
  function automatic logic [8:0] down_max_speed(input logic [GEAR_W-1:0] g);
    logic [8:0] lim;
    case (g)
      3'd1:    lim = 9'd60;
      3'd2:    lim = 9'd100;
      3'd3:    lim = 9'd150;
      3'd4:    lim = 9'd210;
      3'd5:    lim = 9'd260;
      default: lim = 9'd511;
    endcase
    return lim;
  endfunction

  // One gear up or down, one bit wider so that 0-1 and MAX+1 stay visible.
  function automatic logic [GEAR_W:0] shift_target(input logic up,
                                                   input logic [GEAR_W-1:0] g);
    logic [GEAR_W:0] t;
    if (up) begin
      t = {1'b0, g} + {{GEAR_W{1'b0}}, 1'b1};
    end else begin
      t = {1'b0, g} - {{GEAR_W{1'b0}}, 1'b1};
    end
    return t;
  endfunction

endpackage

// File: rtl/auto_shift_policy.sv
// Automatic shift policy: rpm hold counters plus the overload escape,
// producing one-clk auto_up / auto_dn request pulses for the sequencer.
module auto_shift_policy
  import car_pkg::*;
#(
  parameter int MAX_GEAR   = MAX_GEAR_DEFAULT,
  parameter int UP_RPM     = 6000,
  parameter int DOWN_RPM   = 2000,
  parameter int HOLD_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_10hz,
  input  logic              auto_mode,
  input  logic              idle,
  input  logic              manual_clr,
  input  logic [GEAR_W-1:0] gear,
  input  logic [13:0]       rpm,
  input  logic              overload,
  output logic              auto_up,
  output logic              auto_dn
);

  localparam int HW = 3;

  logic [HW-1:0] up_cnt_r, up_cnt_n_s, up_inc_s;
  logic [HW-1:0] dn_cnt_r, dn_cnt_n_s, dn_inc_s;
  logic          auto_up_r, auto_up_n_s;
  logic          auto_dn_r, auto_dn_n_s;
  logic          active_s;

  // Next hold-counter values and request pulses, evaluated on ticks only.
  always_comb begin
    up_cnt_n_s  = up_cnt_r;
    dn_cnt_n_s  = dn_cnt_r;
    auto_up_n_s = 1'b0;
    auto_dn_n_s = 1'b0;
    up_inc_s    = (up_cnt_r == {HW{1'b1}}) ? up_cnt_r : up_cnt_r + HW'(1);
    dn_inc_s    = (dn_cnt_r == {HW{1'b1}}) ? dn_cnt_r : dn_cnt_r + HW'(1);
    // Auto never touches neutral, and a manual pulse restarts the hold.
    active_s    = auto_mode & idle & (gear != GEAR_W'(GEAR_N)) & ~manual_clr;
    if (!active_s) begin
      up_cnt_n_s = '0;
      dn_cnt_n_s = '0;
    end else if (tick_10hz) begin
      if (overload && (gear < GEAR_W'(MAX_GEAR))) begin
        auto_up_n_s = 1'b1;
        up_cnt_n_s  = '0;
        dn_cnt_n_s  = '0;
      end else begin
        if ((rpm >= 14'(UP_RPM)) && (gear < GEAR_W'(MAX_GEAR))) begin
          up_cnt_n_s = up_inc_s;
        end else begin
          up_cnt_n_s = '0;
        end
        if ((rpm <= 14'(DOWN_RPM)) && (gear > GEAR_W'(1))) begin
          dn_cnt_n_s = dn_inc_s;
        end else begin
          dn_cnt_n_s = '0;
        end
        if (up_cnt_n_s == HW'(HOLD_TICKS)) begin
          auto_up_n_s = 1'b1;
          up_cnt_n_s  = '0;
        end else begin
          auto_up_n_s = 1'b0;
        end
        if (dn_cnt_n_s == HW'(HOLD_TICKS)) begin
          auto_dn_n_s = 1'b1;
          dn_cnt_n_s  = '0;
        end else begin
          auto_dn_n_s = 1'b0;
        end
      end
    end else begin
      up_cnt_n_s = up_cnt_r;
      dn_cnt_n_s = dn_cnt_r;
    end
  end

  // Hold counters and registered request pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      up_cnt_r  <= '0;
      dn_cnt_r  <= '0;
      auto_up_r <= 1'b0;
      auto_dn_r <= 1'b0;
    end else begin
      up_cnt_r  <= up_cnt_n_s;
      dn_cnt_r  <= dn_cnt_n_s;
      auto_up_r <= auto_up_n_s;
      auto_dn_r <= auto_dn_n_s;
    end
  end

  assign auto_up = auto_up_r;
  assign auto_dn = auto_dn_r;

endmodule

// File: rtl/gear_shift_ctrl.sv
// Gear-shift sequencer: resolves manual/auto requests, checks legality,
// runs clutch-open / settle timing and gates the throttle.
module gear_shift_ctrl
  import car_pkg::*;
#(
  parameter int MAX_GEAR     = MAX_GEAR_DEFAULT,
  parameter int SHIFT_TICKS  = 3,
  parameter int SETTLE_TICKS = 5,
  parameter int UP_RPM       = 6000,
  parameter int DOWN_RPM     = 2000,
  parameter int HOLD_TICKS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_10hz,
  input  logic        shift_up,
  input  logic        shift_down,
  input  logic        auto_mode,
  input  logic        throttle_req,
  input  logic [8:0]  speed_kmh,
  input  logic [13:0] rpm,
  input  logic        overload,
  output logic [2:0]  gear,
  output logic        throttle_out,
  output logic        clutch_open,
  output logic        shift_busy,
  output logic        shift_reject
);

  localparam int CW = 3;

  shift_state_e      state_r, state_n_s;
  logic [CW-1:0]     cnt_r, cnt_n_s;
  logic [GEAR_W-1:0] tgt_r, tgt_n_s, gear_r, gear_n_s;
  logic              clutch_r, clutch_n_s, busy_r, busy_n_s;
  logic              reject_r, reject_n_s, throttle_r;
  logic              manual_s, auto_up_s, auto_dn_s;
  logic              req_s, req_up_s, req_ok_s;
  logic [GEAR_W:0]   req_tgt_s;

  // A shift is refused when it leaves the gear range or engages a gear
  // (from above, or out of neutral) faster than that gear tolerates.
  function automatic logic shift_legal(input logic up, input logic [GEAR_W-1:0] g,
                                       input logic [GEAR_W:0] t, input logic [8:0] spd);
    logic ok;
    if (!up && (g == GEAR_W'(GEAR_N))) begin
      ok = 1'b0;
    end else if (up && (t > (GEAR_W+1)'(MAX_GEAR))) begin
      ok = 1'b0;
    end else if ((t >= (GEAR_W+1)'(1)) && (!up || (g == GEAR_W'(GEAR_N))) &&
                 (spd > down_max_speed(t[GEAR_W-1:0]))) begin
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

  assign manual_s = shift_up | shift_down;

  auto_shift_policy #(
    .MAX_GEAR   (MAX_GEAR),
    .UP_RPM     (UP_RPM),
    .DOWN_RPM   (DOWN_RPM),
    .HOLD_TICKS (HOLD_TICKS)
  ) u_policy (
    .clk        (clk),
    .rst        (rst),
    .tick_10hz  (tick_10hz),
    .auto_mode  (auto_mode),
    .idle       (state_r == ST_IDLE),
    .manual_clr (manual_s),
    .gear       (gear_r),
    .rpm        (rpm),
    .overload   (overload),
    .auto_up    (auto_up_s),
    .auto_dn    (auto_dn_s)
  );

  // Pick the request for this clk (manual beats auto) and judge it.
  always_comb begin
    req_s    = 1'b0;
    req_up_s = 1'b0;
    if (manual_s) begin
      req_s    = 1'b1;
      req_up_s = shift_up;
    end else if (auto_up_s || auto_dn_s) begin
      req_s    = 1'b1;
      req_up_s = auto_up_s;
    end else begin
      req_s    = 1'b0;
      req_up_s = 1'b0;
    end
    req_tgt_s = shift_target(req_up_s, gear_r);
    req_ok_s  = shift_legal(req_up_s, gear_r, req_tgt_s, speed_kmh);
  end

  // Sequencer next state: accept/reject in IDLE, tick timing afterwards.
  always_comb begin
    state_n_s  = state_r;
    cnt_n_s    = cnt_r;
    tgt_n_s    = tgt_r;
    gear_n_s   = gear_r;
    clutch_n_s = clutch_r;
    busy_n_s   = busy_r;
    reject_n_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (shift_up && shift_down) begin
          reject_n_s = 1'b1;
        end else if (req_s) begin
          if (req_ok_s) begin
            state_n_s  = ST_CLUTCH;
            clutch_n_s = 1'b1;
            busy_n_s   = 1'b1;
            tgt_n_s    = req_tgt_s[GEAR_W-1:0];
            cnt_n_s    = '0;
          end else begin
            reject_n_s = 1'b1;
          end
        end else begin
          reject_n_s = 1'b0;
        end
      end
      ST_CLUTCH: begin
        reject_n_s = manual_s;
        if (tick_10hz) begin
          if (cnt_r == CW'(SHIFT_TICKS - 1)) begin
            gear_n_s   = tgt_r;
            clutch_n_s = 1'b0;
            state_n_s  = ST_SETTLE;
            cnt_n_s    = '0;
          end else begin
            cnt_n_s = cnt_r + CW'(1);
          end
        end else begin
          cnt_n_s = cnt_r;
        end
      end
      ST_SETTLE: begin
        reject_n_s = manual_s;
        if (tick_10hz) begin
          if (cnt_r == CW'(SETTLE_TICKS - 1)) begin
            busy_n_s  = 1'b0;
            state_n_s = ST_IDLE;
            cnt_n_s   = '0;
          end else begin
            cnt_n_s = cnt_r + CW'(1);
          end
        end else begin
          cnt_n_s = cnt_r;
        end
      end
      default: begin
        state_n_s  = ST_IDLE;
        clutch_n_s = 1'b0;
        busy_n_s   = 1'b0;
        cnt_n_s    = '0;
      end
    endcase
  end

  // State and output registers; throttle uses the next clutch value so it
  // is low on exactly the clks where clutch_open is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      tgt_r      <= GEAR_W'(GEAR_N);
      gear_r     <= GEAR_W'(GEAR_N);
      clutch_r   <= 1'b0;
      busy_r     <= 1'b0;
      reject_r   <= 1'b0;
      throttle_r <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      cnt_r      <= cnt_n_s;
      tgt_r      <= tgt_n_s;
      gear_r     <= gear_n_s;
      clutch_r   <= clutch_n_s;
      busy_r     <= busy_n_s;
      reject_r   <= reject_n_s;
      throttle_r <= throttle_req & ~clutch_n_s & ~overload;
    end
  end

  assign gear         = gear_r;
  assign clutch_open  = clutch_r;
  assign shift_busy   = busy_r;
  assign shift_reject = reject_r;
  assign throttle_out = throttle_r;

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// Bench for gear_shift_ctrl: a tick-countdown behavioural model checked
// every clk, plus hand-computed checkpoints along a directed scenario.
module tb_gear_shift_ctrl;

  logic        clk, rst, tick_10hz, shift_up, shift_down, auto_mode;
  logic        throttle_req, overload;
  logic [8:0]  speed_kmh;
  logic [13:0] rpm;
  logic [2:0]  gear;
  logic        throttle_out, clutch_open, shift_busy, shift_reject;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model state
  int m_gear = 0, m_tgt = 0, m_left = 0, m_uph = 0, m_dnh = 0;
  bit m_busy = 0, m_clutch = 0, m_rej = 0, m_thr = 0, m_aup = 0, m_adn = 0;
  int lim_tab [0:7] = '{999, 60, 100, 150, 210, 260, 999, 999};

  // hand checkpoints
  string pin_nm = "";
  int pin_g = 0, pin_b = 0, pin_c = 0, pin_r = 0, pin_t = 0;
  int pin_seq = 0, pin_seen = 0;

  gear_shift_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .tick_10hz    (tick_10hz),
    .shift_up     (shift_up),
    .shift_down   (shift_down),
    .auto_mode    (auto_mode),
    .throttle_req (throttle_req),
    .speed_kmh    (speed_kmh),
    .rpm          (rpm),
    .overload     (overload),
    .gear         (gear),
    .throttle_out (throttle_out),
    .clutch_open  (clutch_open),
    .shift_busy   (shift_busy),
    .shift_reject (shift_reject)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clk of the reference behaviour, from the inputs sampled at this edge.
  task automatic model_step();
    int g0, t;
    bit b0, man, have, up, bad_req;
    if (rst) begin
      m_gear = 0; m_tgt = 0; m_left = 0; m_uph = 0; m_dnh = 0;
      m_busy = 0; m_clutch = 0; m_rej = 0; m_thr = 0; m_aup = 0; m_adn = 0;
    end else begin
      g0 = m_gear; b0 = m_busy; man = shift_up | shift_down;
      m_rej = 0; have = 0; up = 0;
      if (b0) begin
        m_rej = man;
        if (tick_10hz) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            if (m_clutch) begin
              m_gear = m_tgt; m_clutch = 0; m_left = 5;
            end else begin
              m_busy = 0;
            end
          end
        end
      end else begin
        if (shift_up && shift_down) m_rej = 1;
        else if (man) begin have = 1; up = shift_up; end
        else if (m_aup || m_adn) begin have = 1; up = m_aup; end
        if (have) begin
          t = up ? g0 + 1 : g0 - 1;
          bad_req = (t < 0) || (t > 6) ||
                    ((t >= 1) && (!up || g0 == 0) && (int'(speed_kmh) > lim_tab[t]));
          if (bad_req) m_rej = 1;
          else begin
            m_busy = 1; m_clutch = 1; m_left = 3; m_tgt = t;
          end
        end
      end
      m_aup = 0; m_adn = 0;
      if (!(auto_mode && !b0 && g0 != 0 && !man)) begin
        m_uph = 0; m_dnh = 0;
      end else if (tick_10hz) begin
        if (overload && g0 < 6) begin
          m_aup = 1; m_uph = 0; m_dnh = 0;
        end else begin
          m_uph = (int'(rpm) >= 6000 && g0 < 6) ? m_uph + 1 : 0;
          m_dnh = (int'(rpm) <= 2000 && g0 > 1) ? m_dnh + 1 : 0;
          if (m_uph == 4) begin m_aup = 1; m_uph = 0; end
          if (m_dnh == 4) begin m_adn = 1; m_dnh = 0; end
        end
      end
      m_thr = throttle_req && !m_clutch && !overload;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process: model every clk, hand checkpoints when posted.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("gear", int'(gear), m_gear);
        chk("clutch_open", int'(clutch_open), int'(m_clutch));
        chk("shift_busy", int'(shift_busy), int'(m_busy));
        chk("shift_reject", int'(shift_reject), int'(m_rej));
        chk("throttle_out", int'(throttle_out), int'(m_thr));
        if (pin_seq != pin_seen) begin
          pin_seen = pin_seq;
          chk($sformatf("%s.gear", pin_nm), int'(gear), pin_g);
          chk($sformatf("%s.busy", pin_nm), int'(shift_busy), pin_b);
          chk($sformatf("%s.clutch", pin_nm), int'(clutch_open), pin_c);
          chk($sformatf("%s.reject", pin_nm), int'(shift_reject), pin_r);
          chk($sformatf("%s.throttle", pin_nm), int'(throttle_out), pin_t);
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      shift_up = 1'b0; shift_down = 1'b0; tick_10hz = 1'b0;
    end
  endtask

  task automatic ticks(int n);
    repeat (n) begin
      tick_10hz = 1'b1;
      cyc(3);
    end
  endtask

  task automatic pin(string nm, int g, int b, int c, int r, int th);
    pin_nm = nm; pin_g = g; pin_b = b; pin_c = c; pin_r = r; pin_t = th;
    pin_seq++;
  endtask

  task automatic up_shift();
    shift_up = 1'b1; cyc(1); ticks(8);
  endtask

  task automatic dn_shift();
    shift_down = 1'b1; cyc(1); ticks(8);
  endtask

  initial begin
    rst = 1'b1; tick_10hz = 1'b0; shift_up = 1'b0; shift_down = 1'b0;
    auto_mode = 1'b0; throttle_req = 1'b0; overload = 1'b0;
    speed_kmh = 9'd0; rpm = 14'd3000;
    cyc(2);
    chk_en = 1'b1;
    cyc(1);
    pin("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    shift_down = 1'b1; cyc(1);
    pin("dn_from_n", 0, 0, 0, 1, 0);

    // first shift, with a tick in the accept clk that must not count
    shift_up = 1'b1; tick_10hz = 1'b1; cyc(1);
    pin("t1_accept", 0, 1, 1, 0, 0);
    ticks(2); pin("t1_clutch2", 0, 1, 1, 0, 0);
    ticks(1); pin("t1_engaged", 1, 1, 0, 0, 0);
    ticks(4); pin("t1_settle4", 1, 1, 0, 0, 0);
    ticks(1); pin("t1_done", 1, 0, 0, 0, 0);
    up_shift(); up_shift();
    pin("gear3", 3, 0, 0, 0, 0);

    // downshift speed limit for gear 2 is 100 km/h
    speed_kmh = 9'd180; shift_down = 1'b1; cyc(1);
    pin("t2_rej180", 3, 0, 0, 1, 0);
    cyc(1); pin("t2_rej_pulse", 3, 0, 0, 0, 0);
    speed_kmh = 9'd140; shift_down = 1'b1; cyc(1);
    pin("t2_rej140", 3, 0, 0, 1, 0);
    speed_kmh = 9'd100; dn_shift();
    pin("t2_gear2", 2, 0, 0, 0, 0);

    speed_kmh = 9'd0;
    shift_up = 1'b1; shift_down = 1'b1; cyc(1);
    pin("t3_both", 2, 0, 0, 1, 0);
    shift_up = 1'b1; cyc(1); ticks(3);
    shift_up = 1'b1; cyc(1);
    pin("t3_busy_rej", 3, 1, 0, 1, 0);
    ticks(5); pin("t3_done", 3, 0, 0, 0, 0);
    dn_shift();

    // auto policy at gear 2 with throttle held
    auto_mode = 1'b1; throttle_req = 1'b1;
    rpm = 14'd6500; ticks(2);
    rpm = 14'd3000; ticks(1);
    rpm = 14'd6500; ticks(1);
    pin("t4_dip", 2, 0, 0, 0, 1);
    auto_mode = 1'b0; cyc(1); auto_mode = 1'b1;
    ticks(4);
    pin("t4_auto", 2, 1, 1, 0, 0);
    rpm = 14'd4000; ticks(3);
    pin("t4_engaged", 3, 1, 0, 0, 1);
    ticks(5); pin("t4_done", 3, 0, 0, 0, 1);
    overload = 1'b1; ticks(1);
    pin("ovl_accept", 3, 1, 1, 0, 0);
    overload = 1'b0; ticks(8);
    pin("ovl_gear4", 4, 0, 0, 0, 1);
    auto_mode = 1'b0;
    throttle_req = 1'b0; cyc(1);
    pin("thr_off", 4, 0, 0, 0, 0);
    throttle_req = 1'b1; cyc(1);
    pin("thr_on", 4, 0, 0, 0, 1);

    // reset in the middle of CLUTCH
    shift_up = 1'b1; cyc(1); ticks(1);
    rst = 1'b1; cyc(1);
    pin("t6_reset", 0, 0, 0, 0, 0);
    rst = 1'b0; throttle_req = 1'b0;

    speed_kmh = 9'd61; shift_up = 1'b1; cyc(1);
    pin("n_up_61", 0, 0, 0, 1, 0);
    speed_kmh = 9'd60; up_shift();
    pin("n_up_60", 1, 0, 0, 0, 0);
    speed_kmh = 9'd0;
    repeat (5) up_shift();
    pin("gear6", 6, 0, 0, 0, 0);
    shift_up = 1'b1; cyc(1);
    pin("max_rej", 6, 0, 0, 1, 0);

    auto_mode = 1'b1; rpm = 14'd1500; ticks(4);
    pin("auto_dn", 6, 1, 1, 0, 0);
    rpm = 14'd3000; ticks(8);
    pin("auto_dn_done", 5, 0, 0, 0, 0);
    auto_mode = 1'b0;
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
